// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control unit with memory-wait watchdog.
// Define MULTICYCLE_CTRL_TRAP_EN to trap illegal instructions; otherwise they retire as NOPs.
module multicycle_ctrl #(
   parameter int unsigned ALU_CTRL_W = 4,
   parameter int unsigned WAIT_MAX   = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [5:0]            opcode,
   input  logic [5:0]            funct,
   input  logic                  zero,
   input  logic                  mem_done,
   output logic                  pc_en,
   output logic [1:0]            pc_src,
   output logic                  alu_src_a,
   output logic [1:0]            alu_src_b,
   output logic                  imm_zext,
   output logic                  reg_write,
   output logic [1:0]            reg_dest,
   output logic [1:0]            mem_to_reg,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic                  ir_write,
   output logic [ALU_CTRL_W-1:0] alu_control,
   output logic                  mem_err,
   output logic                  exc,
   output logic [3:0]            state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEM_ADR = 4'd2, S_MEM_RD = 4'd3,
      S_MEM_WB = 4'd4,  S_MEM_WR = 4'd5,  S_EXEC    = 4'd6, S_ALU_WB = 4'd7,
      S_BRANCH = 4'd8,  S_IEXEC  = 4'd9,  S_IWB     = 4'd10, S_JUMP  = 4'd11,
      S_JAL    = 4'd12, S_TRAP   = 4'd13
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_SRA = 6'b000011;
   localparam logic [5:0] FN_JR  = 6'b001000;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SLL = 4'b1100;
   localparam logic [3:0] ALU_SRL = 4'b1101;
   localparam logic [3:0] ALU_SRA = 4'b1111;

   localparam int unsigned CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

`ifdef MULTICYCLE_CTRL_TRAP_EN
   localparam state_t S_ILLEGAL = S_TRAP;
`else
   localparam state_t S_ILLEGAL = S_FETCH;
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_err_q;
   logic             waiting, abort;
   logic             r_legal, i_zext;
   logic [3:0]       r_alu, i_alu, alu_op;

   always_comb begin
      r_legal = 1'b1;
      r_alu   = ALU_ADD;
      case (funct)
         FN_ADD:  r_alu = ALU_ADD;
         FN_SUB:  r_alu = ALU_SUB;
         FN_AND:  r_alu = ALU_AND;
         FN_OR:   r_alu = ALU_OR;
         FN_SLT:  r_alu = ALU_SLT;
         FN_SLL:  r_alu = ALU_SLL;
         FN_SRL:  r_alu = ALU_SRL;
         FN_SRA:  r_alu = ALU_SRA;
         FN_JR:   r_alu = ALU_ADD;
         default: r_legal = 1'b0;
      endcase
      i_alu  = ALU_ADD;
      i_zext = 1'b0;
      case (opcode)
         OP_ANDI: begin i_alu = ALU_AND; i_zext = 1'b1; end
         OP_ORI:  begin i_alu = ALU_OR;  i_zext = 1'b1; end
         OP_SLTI: i_alu = ALU_SLT;
         default: i_alu = ALU_ADD;
      endcase
   end

   // A done arriving in the limit cycle wins over the abort.
   always_comb begin
      waiting = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
      abort   = waiting && (WAIT_MAX != 0) && (cnt_q == CNT_W'(WAIT_MAX)) && !mem_done;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:   if (abort) state_d = S_FETCH;
                    else if (mem_done) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:   state_d = S_MEM_ADR;
               OP_R: begin
                  if (!r_legal)          state_d = S_ILLEGAL;
                  else if (funct == FN_JR) state_d = S_JUMP;
                  else                   state_d = S_EXEC;
               end
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXEC;
               OP_J:           state_d = S_JUMP;
               OP_JAL:         state_d = S_JAL;
               default:        state_d = S_ILLEGAL;
            endcase
         end
         S_MEM_ADR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:  if (abort) state_d = S_FETCH;
                    else if (mem_done) state_d = S_MEM_WB;
         S_MEM_WR:  if (abort || mem_done) state_d = S_FETCH;
         S_EXEC:    state_d = S_ALU_WB;
         S_IEXEC:   state_d = S_IWB;
         S_TRAP:    state_d = S_TRAP;
         default:   state_d = S_FETCH;
      endcase

      cnt_d = cnt_q;
      if (abort || (state_d != state_q)) cnt_d = '0;
      else if (waiting && !mem_done && (WAIT_MAX != 0)) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         cnt_q     <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mem_err_q <= abort;
      end
   end

`ifdef MULTICYCLE_CTRL_TRAP_EN
   logic exc_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 exc_q <= 1'b0;
      else if (state_d == S_TRAP) exc_q <= 1'b1;
   end
   assign exc = exc_q;
`else
   assign exc = 1'b0;
`endif

   always_comb begin
      pc_en      = 1'b0;
      pc_src     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      imm_zext   = 1'b0;
      reg_write  = 1'b0;
      reg_dest   = 2'b00;
      mem_to_reg = 2'b00;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      alu_op     = ALU_AND;
      case (state_q)
         S_FETCH: begin
            mem_read  = !abort;
            alu_src_b = 2'b01;
            alu_op    = ALU_ADD;
            ir_write  = mem_done;
            pc_en     = mem_done;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            alu_op    = ALU_ADD;
         end
         S_MEM_ADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = ALU_ADD;
         end
         S_MEM_RD: mem_read = !abort;
         S_MEM_WB: begin
            mem_to_reg = 2'b01;
            reg_write  = 1'b1;
         end
         S_MEM_WR: mem_write = !abort;
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = r_alu;
         end
         S_ALU_WB: begin
            reg_dest  = 2'b01;
            reg_write = 1'b1;
         end
         S_IEXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = i_alu;
            imm_zext  = i_zext;
         end
         S_IWB: reg_write = 1'b1;
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_src    = 2'b01;
            pc_en     = (opcode == OP_BNE) ? !zero : zero;
         end
         S_JUMP: begin
            pc_en  = 1'b1;
            pc_src = (opcode == OP_R) ? 2'b11 : 2'b10;
         end
         S_JAL: begin
            pc_en      = 1'b1;
            pc_src     = 2'b10;
            reg_dest   = 2'b10;
            mem_to_reg = 2'b10;
            reg_write  = 1'b1;
         end
         default: pc_en = 1'b0;
      endcase

      if (!rst_n) begin
         pc_en      = 1'b0;
         pc_src     = 2'b00;
         alu_src_a  = 1'b0;
         alu_src_b  = 2'b00;
         imm_zext   = 1'b0;
         reg_write  = 1'b0;
         reg_dest   = 2'b00;
         mem_to_reg = 2'b00;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         alu_op     = ALU_AND;
      end
   end

   assign alu_control = ALU_CTRL_W'(alu_op);
   assign mem_err     = mem_err_q;
   assign state       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control words are queued as
// stimulus is driven and compared at the falling edge. Honors MULTICYCLE_CTRL_TRAP_EN.
module tb_multicycle_ctrl;

   logic       clk, rst_n, zero, mem_done;
   logic [5:0] opcode, funct;
   logic       pc_en, alu_src_a, imm_zext, reg_write, mem_read, mem_write, ir_write;
   logic       mem_err, exc;
   logic [1:0] pc_src, alu_src_b, reg_dest, mem_to_reg;
   logic [3:0] alu_control, state;

   multicycle_ctrl #(.ALU_CTRL_W(4), .WAIT_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_done(mem_done), .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .imm_zext(imm_zext), .reg_write(reg_write),
      .reg_dest(reg_dest), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .alu_control(alu_control),
      .mem_err(mem_err), .exc(exc), .state(state)
   );

   typedef struct packed {
      logic [3:0] st;
      logic       pc_en;
      logic [1:0] pc_src;
      logic       a;
      logic [1:0] b;
      logic       zx;
      logic       rw;
      logic [1:0] rd;
      logic [1:0] m2r;
      logic       mr;
      logic       mw;
      logic       irw;
      logic [3:0] alu;
      logic       err;
      logic       exc;
   } obs_t;

   obs_t       exp_q[$];
   string      tag_q[$];
   int         n_err = 0;
   int         n_chk = 0;
   logic [5:0] nxt_op = '0;
   logic [5:0] nxt_fn = '0;

   logic [5:0] r_fn  [7] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010,
                             6'b000000, 6'b000010, 6'b000011};
   logic [3:0] r_alu [7] = '{4'b0110, 4'b0000, 4'b0001, 4'b0111,
                             4'b1100, 4'b1101, 4'b1111};
   logic [5:0] i_op  [4] = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
   logic [3:0] i_alu [4] = '{4'b0010, 4'b0000, 4'b0001, 4'b0111};
   logic       i_zx  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish (errors=%0d)", n_err);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic obs_t sample();
      obs_t o;
      o.st = state;      o.pc_en = pc_en;     o.pc_src = pc_src;   o.a = alu_src_a;
      o.b = alu_src_b;   o.zx = imm_zext;     o.rw = reg_write;    o.rd = reg_dest;
      o.m2r = mem_to_reg; o.mr = mem_read;    o.mw = mem_write;    o.irw = ir_write;
      o.alu = alu_control; o.err = mem_err;   o.exc = exc;
      return o;
   endfunction

   function automatic obs_t base(input logic [3:0] st);
      obs_t o = '0;
      o.st = st;
      return o;
   endfunction

   function automatic obs_t o_fetch(input logic done);
      obs_t o = base(4'd0);
      o.mr = 1'b1; o.b = 2'b01; o.alu = 4'b0010; o.irw = done; o.pc_en = done;
      return o;
   endfunction

   function automatic obs_t o_decode();
      obs_t o = base(4'd1);
      o.b = 2'b11; o.alu = 4'b0010;
      return o;
   endfunction

   function automatic obs_t o_mem_adr();
      obs_t o = base(4'd2);
      o.a = 1'b1; o.b = 2'b10; o.alu = 4'b0010;
      return o;
   endfunction

   function automatic obs_t o_mem_rd();
      obs_t o = base(4'd3);
      o.mr = 1'b1;
      return o;
   endfunction

   function automatic obs_t o_mem_wb();
      obs_t o = base(4'd4);
      o.rw = 1'b1; o.m2r = 2'b01;
      return o;
   endfunction

   function automatic obs_t o_mem_wr();
      obs_t o = base(4'd5);
      o.mw = 1'b1;
      return o;
   endfunction

   function automatic obs_t o_exec(input logic [3:0] alu);
      obs_t o = base(4'd6);
      o.a = 1'b1; o.alu = alu;
      return o;
   endfunction

   function automatic obs_t o_alu_wb();
      obs_t o = base(4'd7);
      o.rw = 1'b1; o.rd = 2'b01;
      return o;
   endfunction

   function automatic obs_t o_iexec(input logic [3:0] alu, input logic zx);
      obs_t o = base(4'd9);
      o.a = 1'b1; o.b = 2'b10; o.alu = alu; o.zx = zx;
      return o;
   endfunction

   function automatic obs_t o_iwb();
      obs_t o = base(4'd10);
      o.rw = 1'b1;
      return o;
   endfunction

   function automatic obs_t o_branch(input logic pe);
      obs_t o = base(4'd8);
      o.a = 1'b1; o.alu = 4'b0110; o.pc_src = 2'b01; o.pc_en = pe;
      return o;
   endfunction

   function automatic obs_t o_jump(input logic [1:0] src);
      obs_t o = base(4'd11);
      o.pc_en = 1'b1; o.pc_src = src;
      return o;
   endfunction

   function automatic obs_t o_jal();
      obs_t o = base(4'd12);
      o.pc_en = 1'b1; o.pc_src = 2'b10; o.rd = 2'b10; o.m2r = 2'b10; o.rw = 1'b1;
      return o;
   endfunction

   task automatic ir(input logic [5:0] op, input logic [5:0] fn);
      nxt_op = op;
      nxt_fn = fn;
   endtask

   // One clock cycle: drive inputs after the rising edge, queue the expectation, check at the falling edge.
   task automatic cyc(input logic done, input logic z, input obs_t e, input string tag);
      obs_t  want;
      string t;
      @(posedge clk);
      #1;
      opcode = nxt_op; funct = nxt_fn; mem_done = done; zero = z;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
      want = exp_q.pop_front();
      t    = tag_q.pop_front();
      check(t, 32'(sample()), 32'(want));
   endtask

   task automatic do_reset(input int n);
      #1;
      rst_n = 1'b0;
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, base(4'd0), "reset");
      #1;
      rst_n    = 1'b1;
      mem_done = 1'b0;
   endtask

   task automatic illegal(input logic [5:0] op, input logic [5:0] fn, input string tag);
      obs_t o;
      ir(op, fn);
      cyc(1'b1, 1'b0, o_fetch(1'b1), {tag, "_fetch"});
      cyc(1'b0, 1'b0, o_decode(), {tag, "_decode"});
`ifdef MULTICYCLE_CTRL_TRAP_EN
      o = base(4'd13);
      o.exc = 1'b1;
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, o, {tag, "_trap"});
      do_reset(2);
`else
      o = o_fetch(1'b0);
      cyc(1'b0, 1'b0, o, {tag, "_nop"});
`endif
   endtask

   initial begin
      obs_t o;
      rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_done = 1'b0;
      do_reset(3);

      ir(6'b000000, 6'b100000);
      cyc(1'b1, 1'b0, o_fetch(1'b1), "add_fetch");
      cyc(1'b0, 1'b0, o_decode(), "add_decode");
      cyc(1'b0, 1'b0, o_exec(4'b0010), "add_exec");
      cyc(1'b0, 1'b0, o_alu_wb(), "add_wb");

      for (int i = 0; i < 7; i++) begin
         ir(6'b000000, r_fn[i]);
         cyc(1'b1, 1'b0, o_fetch(1'b1), $sformatf("r%0d_fetch", i));
         cyc(1'b0, 1'b0, o_decode(), $sformatf("r%0d_decode", i));
         cyc(1'b0, 1'b0, o_exec(r_alu[i]), $sformatf("r%0d_exec", i));
         cyc(1'b0, 1'b0, o_alu_wb(), $sformatf("r%0d_wb", i));
      end

      for (int i = 0; i < 4; i++) begin
         ir(i_op[i], 6'b101010);
         cyc(1'b1, 1'b0, o_fetch(1'b1), $sformatf("i%0d_fetch", i));
         cyc(1'b0, 1'b0, o_decode(), $sformatf("i%0d_decode", i));
         cyc(1'b0, 1'b0, o_iexec(i_alu[i], i_zx[i]), $sformatf("i%0d_exec", i));
         cyc(1'b0, 1'b0, o_iwb(), $sformatf("i%0d_wb", i));
      end

      ir(6'b100011, 6'b000000);
      cyc(1'b1, 1'b0, o_fetch(1'b1), "lw_fetch");
      cyc(1'b0, 1'b0, o_decode(), "lw_decode");
      cyc(1'b0, 1'b0, o_mem_adr(), "lw_adr");
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, o_mem_rd(), "lw_rd_wait");
      cyc(1'b1, 1'b0, o_mem_rd(), "lw_rd_done");
      cyc(1'b0, 1'b0, o_mem_wb(), "lw_wb");

      ir(6'b101011, 6'b000000);
      cyc(1'b0, 1'b0, o_fetch(1'b0), "sw_fetch_wait");
      cyc(1'b0, 1'b0, o_fetch(1'b0), "sw_fetch_wait");
      cyc(1'b1, 1'b0, o_fetch(1'b1), "sw_fetch_done");
      cyc(1'b0, 1'b0, o_decode(), "sw_decode");
      cyc(1'b0, 1'b0, o_mem_adr(), "sw_adr");
      cyc(1'b1, 1'b0, o_mem_wr(), "sw_wr");

      for (int i = 0; i < 4; i++) begin
         logic z;
         logic bne;
         z   = i[0];
         bne = !i[1];
         ir(bne ? 6'b000101 : 6'b000100, 6'b000000);
         cyc(1'b1, 1'b0, o_fetch(1'b1), $sformatf("br%0d_fetch", i));
         cyc(1'b0, 1'b0, o_decode(), $sformatf("br%0d_decode", i));
         cyc(1'b0, z, o_branch(bne ? !z : z), $sformatf("br%0d_branch", i));
      end

      ir(6'b000011, 6'b000000);
      cyc(1'b1, 1'b0, o_fetch(1'b1), "jal_fetch");
      cyc(1'b0, 1'b0, o_decode(), "jal_decode");
      cyc(1'b0, 1'b0, o_jal(), "jal_jal");

      ir(6'b000010, 6'b000000);
      cyc(1'b1, 1'b0, o_fetch(1'b1), "j_fetch");
      cyc(1'b0, 1'b0, o_decode(), "j_decode");
      cyc(1'b0, 1'b0, o_jump(2'b10), "j_jump");

      ir(6'b000000, 6'b001000);
      cyc(1'b1, 1'b0, o_fetch(1'b1), "jr_fetch");
      cyc(1'b0, 1'b0, o_decode(), "jr_decode");
      cyc(1'b0, 1'b0, o_jump(2'b11), "jr_jump");

      ir(6'b101011, 6'b000000);
      cyc(1'b1, 1'b0, o_fetch(1'b1), "swlim_fetch");
      cyc(1'b0, 1'b0, o_decode(), "swlim_decode");
      cyc(1'b0, 1'b0, o_mem_adr(), "swlim_adr");
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, o_mem_wr(), "swlim_wait");
      cyc(1'b1, 1'b0, o_mem_wr(), "swlim_done_at_limit");

      ir(6'b101011, 6'b000000);
      cyc(1'b1, 1'b0, o_fetch(1'b1), "swto_fetch");
      cyc(1'b0, 1'b0, o_decode(), "swto_decode");
      cyc(1'b0, 1'b0, o_mem_adr(), "swto_adr");
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, o_mem_wr(), "swto_wait");
      cyc(1'b0, 1'b0, base(4'd5), "swto_abort");
      o = o_fetch(1'b0);
      o.err = 1'b1;
      cyc(1'b0, 1'b0, o, "swto_err_pulse");
      cyc(1'b0, 1'b0, o_fetch(1'b0), "swto_err_clear");
      cyc(1'b1, 1'b0, o_fetch(1'b1), "swto_refetch");
      cyc(1'b0, 1'b0, o_decode(), "swto_redecode");
      cyc(1'b0, 1'b0, o_mem_adr(), "swto_readr");
      cyc(1'b1, 1'b0, o_mem_wr(), "swto_rewr");

      ir(6'b100011, 6'b000000);
      cyc(1'b1, 1'b0, o_fetch(1'b1), "lwrst_fetch");
      cyc(1'b0, 1'b0, o_decode(), "lwrst_decode");
      cyc(1'b0, 1'b0, o_mem_adr(), "lwrst_adr");
      cyc(1'b0, 1'b0, o_mem_rd(), "lwrst_rd");
      do_reset(2);

      illegal(6'b111111, 6'b000000, "badop");
      illegal(6'b000000, 6'b111111, "badfn");

      ir(6'b000000, 6'b100000);
      cyc(1'b1, 1'b0, o_fetch(1'b1), "post_fetch");
      cyc(1'b0, 1'b0, o_decode(), "post_decode");
      cyc(1'b0, 1'b0, o_exec(4'b0010), "post_exec");
      cyc(1'b0, 1'b0, o_alu_wb(), "post_wb");

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multicycle MIPS control unit, successor to the single-configuration controller. It sequences fetch, decode, execute, memory and write-back for an extended instruction set: R-type incl. `jr`, `lw`/`sw`, `beq`/`bne`, `addi`/`andi`/`ori`/`slti`, `j`/`jal`. Memory accesses, including fetch, use a `done` handshake guarded by a wait-timeout watchdog. It sits between the instruction register and the datapath muxes, register file, ALU and memory port.

## Interface
- `ALU_CTRL_W`, 4: width of `alu_control`; must be ≥4; upper bits are zero.
- `WAIT_MAX`, 255: maximum memory wait cycles before abort; 0 disables the watchdog.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset; one clock, reset is asynchronous and active-low.
- `opcode` in 6: instruction[31:26].
- `funct` in 6: instruction[5:0].
- `zero` in 1: ALU zero flag.
- `mem_done` in 1: memory access complete this cycle.
- `pc_en` out 1: PC load.
- `pc_src` out 2: 00 ALU result, 01 ALUOut, 10 jump target, 11 register rs.
- `alu_src_a` out 1: 0 PC, 1 reg A.
- `alu_src_b` out 2: 00 reg B, 01 const 4, 10 ext imm, 11 imm<<2.
- `imm_zext` out 1: zero-extend the immediate (`andi`, `ori`).
- `reg_write` out 1: register file write.
- `reg_dest` out 2: 00 rt, 01 rd, 10 r31.
- `mem_to_reg` out 2: 00 ALUOut, 01 MDR, 10 PC.
- `mem_read`, `mem_write`, `ir_write` out 1: strobes.
- `alu_control` out ALU_CTRL_W: ALU operation.
- `mem_err` out 1: one-cycle pulse on watchdog abort.
- `exc` out 1: illegal-instruction trap flag (see Configuration).
- `state` out 4: current state, debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEM_ADR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC 6, ALU_WB 7, BRANCH 8, IEXEC 9, IWB 10, JUMP 11, JAL 12, TRAP 13.
- **FETCH**
  - Drives `mem_read`=1, src A=0, src B=01, `alu_control`=add (0010).
  - Holds until `mem_done`. In that cycle: `ir_write`=1, `pc_en`=1, `pc_src`=00, then go to DECODE.
- **DECODE**
  - Drives src A=0, src B=11, add.
  - Dispatch: LW/SW→MEM_ADR; R→EXEC, except funct 001000 (`jr`)→JUMP; BEQ/BNE→BRANCH; ADDI/ANDI/ORI/SLTI→IEXEC; J→JUMP; JAL→JAL; other opcodes→illegal.
- **Memory path**
  - MEM_ADR: src A=1, src B=10, add; go to MEM_RD for LW or MEM_WR for SW.
  - MEM_RD: `mem_read`=1 until `mem_done`, then go to MEM_WB.
  - MEM_WB: `reg_dest`=00, `mem_to_reg`=01, `reg_write`=1; go to FETCH.
  - MEM_WR: `mem_write`=1 until `mem_done`, then go to FETCH.
- **Register/immediate path**
  - EXEC: src A=1, src B=00, `alu_control` from funct: add 0010, sub 0110, and 0000, or 0001, slt 0111, sll 1100, srl 1101, sra 1111. Unknown funct→illegal.
  - ALU_WB: `reg_dest`=01, `reg_write`=1.
  - IEXEC: src A=1, src B=10, `alu_control` addi 0010, andi 0000, ori 0001, slti 0111. `imm_zext`=1 for andi/ori only.
  - IWB: `reg_dest`=00, `mem_to_reg`=00, `reg_write`=1.
- **Control-flow path**
  - BRANCH: src A=1, src B=00, sub, `pc_src`=01. `pc_en`=`zero` for BEQ, `pc_en`=!`zero` for BNE.
  - JUMP: `pc_en`=1; `pc_src`=10 for J, 11 for `jr`.
  - JAL: `pc_en`=1, `pc_src`=10, `reg_dest`=10, `mem_to_reg`=10, `reg_write`=1.
- BRANCH, JUMP, JAL, ALU_WB and IWB all return to FETCH.
- Outputs not listed for a state are 0.
- **Watchdog**
  - Counter clears on entry to FETCH, MEM_RD and MEM_WR.
  - Counts each cycle spent waiting without `mem_done`.
  - On reaching WAIT_MAX: strobes drop, `mem_err` pulses in the next cycle, state→FETCH, and no register or PC write occurs.
  - `mem_done` in the same cycle as the limit counts as success.

## Timing
- Zero-wait memory (`mem_done` in the first cycle) gives these cycle counts:
  - R/I-type: 4.
  - LW: 5.
  - SW: 4.
  - BEQ/BNE, J, JAL, `jr`: 3.
- Each extra memory wait cycle adds 1.
- The state register updates on the rising edge.
- Outputs are combinational from state, `opcode`, `funct`, `zero` and `mem_done`.
- While `rst_n`=0:
  - `state`=FETCH, counter=0, `mem_err`=0, `exc`=0.
  - All strobes (`pc_en`, `ir_write`, `reg_write`, `mem_read`, `mem_write`) and all selects are forced to 0.
- Reset mid-access abandons the access immediately. Fetch restarts on the first edge after release.

## Configuration
- Macro `MULTICYCLE_CTRL_TRAP_EN` controls illegal-instruction handling.
- Defined: an illegal opcode or funct enters TRAP. `exc`=1 is registered and sticky, all strobes are 0, and the unit stays in TRAP until `rst_n` is asserted.
- Undefined: an illegal instruction behaves as a NOP. DECODE goes to FETCH with no writes, and `exc` is tied to 0.

## Test plan
- `add` (op 000000, funct 100000), `mem_done` high → states 0,1,6,7,0; `alu_control`=0010 in EXEC; `reg_write`=1 with `reg_dest`=01 in cycle 4.
- `lw` (100011), `mem_done` delayed 3 cycles in MEM_RD → `mem_read` high 4 cycles; `reg_write` with `mem_to_reg`=01 exactly once.
- `bne` (000101) with `zero`=0 → `pc_en`=1, `pc_src`=01 in BRANCH; same instruction with `zero`=1 → `pc_en`=0.
- `jal` (000011) → `reg_dest`=10, `mem_to_reg`=10, `pc_src`=10, `pc_en`=1 in one cycle; next state FETCH.
- WAIT_MAX=4, `mem_done` held low in MEM_WR → `mem_err` single pulse after 4 wait cycles; state=0; no `reg_write`.
- Opcode 111111: with `MULTICYCLE_CTRL_TRAP_EN` → state 13, `exc`=1 held until `rst_n`=0. Without the macro → FETCH, no writes, `exc`=0.
